mac_dot_seq: RTL

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

---
 rtl/mac_dot_seq.sv | 82 ++++++++
 1 files changed

// File: rtl/mac_dot_seq.sv
// Sequential dot-product engine: streams packed byte-pair beats through an external
// zero-latency MAC datapath and accumulates the results into a 32-bit sum.
module mac_dot_seq #(
  parameter int LEN_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [31:0]      din,
  output logic [31:0]      mac_din,
  input  logic [31:0]      mac_dout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [31:0]      acc;
  logic             ovf;
  logic [32:0]      sum;

  // The shared MAC datapath is purely combinational, so its result is
  // consumed in the same cycle the operands are presented.
  assign mac_din = din;
  assign sum     = {1'b0, acc} + {1'b0, mac_dout};

  // Outputs decode directly from the state flop, so din_ready has no
  // combinational dependence on din_valid or res_ready.
  assign din_ready = (state == RUN);
  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign res_data  = acc;
  assign res_ovf   = ovf;

  // NOTE: every register, including the accumulator, is cleared by the async
  // reset so an abandoned job leaves no stale result; all updates use <= so
  // each register samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= len;
            state <= (len == '0) ? HOLD : RUN;
          end
        end
        RUN: begin
          if (din_valid) begin
            acc <= sum[31:0];
            if (sum[32]) ovf <= 1'b1;
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) state <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
